// File: rtl/rv32i_alu.sv
// RV32I integer ALU for OP / OP-IMM instructions.
// A ready strobe captures the operands. Add, sub, logic and compare results are
// registered on the capture edge. Shifts run one bit per cycle in an internal
// register. The output is written only once, at completion, and done is sticky
// until the next capture or reset.
module rv32i_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            is_imm,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            ready,
  output logic [XLEN-1:0] out,
  output logic            done
);

  localparam int SHW = 5;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_shreg;
  logic [SHW-1:0]  r_cnt;
  logic            r_left;
  logic            r_arith;

  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] w_shift_step;
  logic [SHW-1:0]  w_shamt;
  logic            w_is_shift;
  logic            w_sub;
  logic            w_unused;

  assign w_shamt    = in2[SHW-1:0];
  assign w_is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  // An immediate never subtracts, even if the upper immediate bits look like funct7[5].
  assign w_sub      = !is_imm && funct7[5];
  assign w_unused   = ^{funct7[6], funct7[4:0]};

  // Single-cycle result for the non-shift operations, computed from the live inputs.
  always_comb begin
    w_result = '0;
    case (funct3)
      3'b000:  w_result = w_sub ? (in1 - in2) : (in1 + in2);
      3'b010:  w_result = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
      3'b011:  w_result = {{(XLEN-1){1'b0}}, (in1 < in2)};
      3'b100:  w_result = in1 ^ in2;
      3'b110:  w_result = in1 | in2;
      3'b111:  w_result = in1 & in2;
      default: w_result = '0;
    endcase
  end

  // One-bit shift step. The arithmetic fill reuses the current top bit, which
  // remains the original sign bit for the whole operation.
  always_comb begin
    w_shift_step = r_shreg;
    if (r_left) begin
      w_shift_step = {r_shreg[XLEN-2:0], 1'b0};
    end else begin
      w_shift_step = {r_arith & r_shreg[XLEN-1], r_shreg[XLEN-1:1]};
    end
  end

  // Next-state logic. A capture always restarts, whether idle or shifting.
  always_comb begin
    w_state_next = r_state;
    if (ready) begin
      w_state_next = (w_is_shift && (w_shamt != '0)) ? S_SHIFT : S_IDLE;
    end else if ((r_state == S_SHIFT) && (r_cnt == SHW'(1))) begin
      w_state_next = S_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: capture, iterative shift, and the sticky result/done registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_arith <= 1'b0;
      out     <= '0;
      done    <= 1'b0;
    end else if (ready) begin
      r_shreg <= in1;
      r_cnt   <= w_is_shift ? w_shamt : '0;
      r_left  <= (funct3 == 3'b001);
      r_arith <= (funct3 == 3'b101) && funct7[5];
      if (w_is_shift) begin
        if (w_shamt == '0) begin
          out  <= in1;
          done <= 1'b1;
        end else begin
          done <= 1'b0;
        end
      end else begin
        out  <= w_result;
        done <= 1'b1;
      end
    end else if (r_state == S_SHIFT) begin
      r_shreg <= w_shift_step;
      r_cnt   <= r_cnt - SHW'(1);
      if (r_cnt == SHW'(1)) begin
        out  <= w_shift_step;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_alu.sv
// Scoreboard bench for rv32i_alu: each capture pushes its expected result and
// latency, and completion pops and compares them.
module tb_rv32i_alu;

  logic        clk;
  logic        rst;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        is_imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        ready;
  logic [31:0] out;
  logic        done;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  rv32i_alu #(.XLEN(32)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .in1    (in1),
    .in2    (in2),
    .is_imm (is_imm),
    .funct3 (funct3),
    .funct7 (funct7),
    .ready  (ready),
    .out    (out),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic imm, input logic [2:0] f3,
                                        input logic [6:0] f7);
    logic [4:0] n;
    n = b[4:0];
    case (f3)
      3'b000:  model = (!imm && f7[5]) ? a - b : a + b;
      3'b001:  model = a << n;
      3'b010:  model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  model = (a < b) ? 32'd1 : 32'd0;
      3'b100:  model = a ^ b;
      3'b101:  model = f7[5] ? 32'($signed(a) >>> n) : (a >> n);
      3'b110:  model = a | b;
      default: model = a & b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] b);
    if ((f3 == 3'b001 || f3 == 3'b101) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Drive one capture edge; inputs are set at the falling edge.
  task automatic capture(input logic [31:0] a, input logic [31:0] b, input logic imm,
                         input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    in1 = a; in2 = b; is_imm = imm; funct3 = f3; funct7 = f7; ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  // Capture, push expectation, then wait (bounded) for done and compare.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic imm, input logic [2:0] f3, input logic [6:0] f7);
    exp_t e;
    exp_t g;
    int   lat;
    logic [31:0] prev;
    logic changed;
    prev    = out;
    changed = 1'b0;
    capture(a, b, imm, f3, f7);
    e.res = model(a, b, imm, f3, f7);
    e.lat = model_lat(f3, b);
    exp_q.push_back(e);
    lat = 1;
    // scramble operands to show they are no longer needed
    in1 = $urandom; in2 = $urandom; funct3 = 3'($urandom); funct7 = 7'($urandom);
    while (!done && lat < 40) begin
      if (out !== prev) changed = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    g = exp_q.pop_front();
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " out"}, out, g.res);
    check({tag, " latency"}, lat, g.lat);
    if (g.lat > 1) check({tag, " no intermediate out"}, 32'(changed), 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b0; ready = 1'b0; in1 = '0; in2 = '0; is_imm = 1'b0; funct3 = '0; funct7 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out", out, 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ADD / SUB
    run_op("SUB reg", 32'd5, 32'd7, 1'b0, 3'b000, 7'h20);
    run_op("ADD imm", 32'd5, 32'd7, 1'b1, 3'b000, 7'h20);

    // Reset in the middle of a shift
    capture(32'd1, 32'd20, 1'b0, 3'b001, 7'h00);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async reset out", out, 32'd0);
    check("async reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("idle after reset done", 32'(done), 32'd0);
    check("idle after reset out", out, 32'd0);

    // Compares and logic
    run_op("SLT", 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b010, 7'h00);
    run_op("SLTU", 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b011, 7'h00);
    run_op("XOR", 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b100, 7'h00);
    run_op("OR", 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b110, 7'h00);
    run_op("AND", 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b111, 7'h00);

    // Shifts
    run_op("SRA N=4", 32'h8000_0000, 32'd4, 1'b0, 3'b101, 7'h20);
    run_op("SRL N=31", 32'h8000_0000, 32'd31, 1'b0, 3'b101, 7'h00);
    run_op("SLL N=0", 32'h0000_0001, 32'd0, 1'b0, 3'b001, 7'h00);
    run_op("SRAI N=1", 32'h8000_0000, 32'h0000_0401, 1'b1, 3'b101, 7'h20);

    // Restart: a shift in flight is abandoned by a new capture
    capture(32'd1, 32'd31, 1'b0, 3'b001, 7'h00);
    repeat (2) @(posedge clk);
    run_op("restart ADD", 32'd2, 32'd3, 1'b0, 3'b000, 7'h00);
    repeat (35) @(posedge clk);
    #1;
    check("restart no stale out", out, 32'd5);
    check("restart done held", 32'(done), 32'd1);

    // Ready held for two edges: the last capture wins
    @(negedge clk);
    in1 = 32'd9; in2 = 32'd4; is_imm = 1'b0; funct3 = 3'b000; funct7 = 7'h20; ready = 1'b1;
    @(negedge clk);
    funct3 = 3'b110;
    @(negedge clk);
    ready = 1'b0;
    check("ready held last wins", out, 32'd13);

    // Sticky result with inputs wiggling and ready low
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in1 = $urandom; in2 = $urandom; funct3 = 3'($urandom); funct7 = 7'($urandom);
      is_imm = 1'($urandom);
    end
    check("sticky out", out, 32'd13);
    check("sticky done", 32'(done), 32'd1);

    // Random mix of all operations
    for (int i = 0; i < 30; i++) begin
      run_op($sformatf("rand%0d", i), $urandom, $urandom, 1'($urandom),
             3'($urandom), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
